// File: rtl/issue_queue.sv
// Unified ALU issue queue: captures operands at dispatch or from writeback, issues up to
// DISPATCH_WIDTH oldest-index ready ops per cycle on registered outputs; never back-pressured.
module issue_queue #(
  parameter int DISPATCH_WIDTH       = 2,
  parameter int ENTRIES              = 8,
  parameter int PHYS_REGS_ADDR_WIDTH = 6,
  parameter int ALU_CMD_WIDTH        = 4
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                flush_i,
  input  logic [DISPATCH_WIDTH-1:0]                           dp_valid_i,
  input  logic [DISPATCH_WIDTH-1:0][ALU_CMD_WIDTH-1:0]        dp_alu_cmd_i,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] dp_rs1_i,
  input  logic [DISPATCH_WIDTH-1:0]                           dp_rs1_rdy_i,
  input  logic [DISPATCH_WIDTH-1:0][31:0]                     dp_rs1_val_i,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] dp_rs2_i,
  input  logic [DISPATCH_WIDTH-1:0]                           dp_rs2_rdy_i,
  input  logic [DISPATCH_WIDTH-1:0][31:0]                     dp_rs2_val_i,
  input  logic [DISPATCH_WIDTH-1:0]                           dp_op2_type_i,
  input  logic [DISPATCH_WIDTH-1:0][31:0]                     dp_imm_i,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] dp_rd_i,
  output logic                                                dp_ready_o,
  input  logic [DISPATCH_WIDTH-1:0]                           wb_valid_i,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic [DISPATCH_WIDTH-1:0][31:0]                     wb_data_i,
  output logic [DISPATCH_WIDTH-1:0]                           issue_valid_o,
  output logic [DISPATCH_WIDTH-1:0][ALU_CMD_WIDTH-1:0]        issue_alu_cmd_o,
  output logic [DISPATCH_WIDTH-1:0][31:0]                     issue_op1_o,
  output logic [DISPATCH_WIDTH-1:0]                           issue_op2_type_o,
  output logic [DISPATCH_WIDTH-1:0][31:0]                     issue_op2_o,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] issue_phys_rd_o
);

  localparam int W    = DISPATCH_WIDTH;
  localparam int PRA  = PHYS_REGS_ADDR_WIDTH;
  localparam int CNTW = $clog2(ENTRIES + 1);
  localparam logic OP2_IMM = 1'b1;

  typedef struct packed {
    logic                     vld;
    logic [ALU_CMD_WIDTH-1:0] cmd;
    logic                     op2t;
    logic [PRA-1:0]           rd;
    logic [PRA-1:0]           t1;
    logic                     r1;
    logic [31:0]              v1;
    logic [PRA-1:0]           t2;
    logic                     r2;
    logic [31:0]              v2;
  } ent_t;

  ent_t ent_q [ENTRIES];
  ent_t ent_d [ENTRIES];

  logic [W-1:0]                    iss_vld_q, iss_vld_d;
  logic [W-1:0][ALU_CMD_WIDTH-1:0] iss_cmd_q, iss_cmd_d;
  logic [W-1:0][31:0]              iss_op1_q, iss_op1_d;
  logic [W-1:0]                    iss_op2t_q, iss_op2t_d;
  logic [W-1:0][31:0]              iss_op2_q, iss_op2_d;
  logic [W-1:0][PRA-1:0]           iss_rd_q, iss_rd_d;

  logic [CNTW-1:0]    free_cnt;
  logic [ENTRIES-1:0] cand, occ;
  logic               found;

  // Returns {rdy, val}; a pending source picks up the lowest-lane matching broadcast.
  function automatic logic [32:0] capture(input logic [PRA-1:0] tag, input logic rdy,
                                          input logic [31:0] val, input logic [W-1:0] wv,
                                          input logic [W-1:0][PRA-1:0] wr,
                                          input logic [W-1:0][31:0] wd);
    capture = {rdy, val};
    if (!rdy)
      for (int k = W - 1; k >= 0; k--)
        if (wv[k] && wr[k] == tag) capture = {1'b1, wd[k]};
  endfunction

  always_comb begin
    free_cnt = '0;
    for (int e = 0; e < ENTRIES; e++)
      if (!ent_q[e].vld) free_cnt = free_cnt + CNTW'(1);
  end

  assign dp_ready_o = (free_cnt >= CNTW'(W));

  always_comb begin
    ent_d      = ent_q;
    iss_vld_d  = '0;
    iss_cmd_d  = '0;
    iss_op1_d  = '0;
    iss_op2t_d = '0;
    iss_op2_d  = '0;
    iss_rd_d   = '0;
    found      = 1'b0;
    occ        = '0;
    cand       = '0;

    for (int e = 0; e < ENTRIES; e++) begin
      occ[e]  = ent_q[e].vld;
      cand[e] = ent_q[e].vld && ent_q[e].r1 && ent_q[e].r2;
      if (ent_q[e].vld) begin
        {ent_d[e].r1, ent_d[e].v1} = capture(ent_q[e].t1, ent_q[e].r1, ent_q[e].v1,
                                             wb_valid_i, wb_rd_i, wb_data_i);
        {ent_d[e].r2, ent_d[e].v2} = capture(ent_q[e].t2, ent_q[e].r2, ent_q[e].v2,
                                             wb_valid_i, wb_rd_i, wb_data_i);
      end
    end

    for (int l = 0; l < W; l++) begin
      found = 1'b0;
      for (int e = 0; e < ENTRIES; e++) begin
        if (!found && cand[e]) begin
          found         = 1'b1;
          cand[e]       = 1'b0;
          ent_d[e].vld  = 1'b0;
          iss_vld_d[l]  = 1'b1;
          iss_cmd_d[l]  = ent_q[e].cmd;
          iss_op1_d[l]  = ent_q[e].v1;
          iss_op2t_d[l] = ent_q[e].op2t;
          iss_op2_d[l]  = ent_q[e].v2;
          iss_rd_d[l]   = ent_q[e].rd;
        end
      end
    end

    // Allocation sees only start-of-cycle occupancy, so slots granted this cycle stay reserved.
    if (dp_ready_o && !flush_i) begin
      for (int l = 0; l < W; l++) begin
        found = 1'b0;
        for (int e = 0; e < ENTRIES; e++) begin
          if (dp_valid_i[l] && !found && !occ[e]) begin
            found          = 1'b1;
            occ[e]         = 1'b1;
            ent_d[e].vld   = 1'b1;
            ent_d[e].cmd   = dp_alu_cmd_i[l];
            ent_d[e].op2t  = dp_op2_type_i[l];
            ent_d[e].rd    = dp_rd_i[l];
            ent_d[e].t1    = dp_rs1_i[l];
            ent_d[e].t2    = dp_rs2_i[l];
            {ent_d[e].r1, ent_d[e].v1} = capture(dp_rs1_i[l], dp_rs1_rdy_i[l], dp_rs1_val_i[l],
                                                 wb_valid_i, wb_rd_i, wb_data_i);
            if (dp_op2_type_i[l] == OP2_IMM)
              {ent_d[e].r2, ent_d[e].v2} = {1'b1, dp_imm_i[l]};
            else
              {ent_d[e].r2, ent_d[e].v2} = capture(dp_rs2_i[l], dp_rs2_rdy_i[l], dp_rs2_val_i[l],
                                                   wb_valid_i, wb_rd_i, wb_data_i);
          end
        end
      end
    end

    if (flush_i) begin
      for (int e = 0; e < ENTRIES; e++) ent_d[e].vld = 1'b0;
      iss_vld_d  = '0;
      iss_cmd_d  = '0;
      iss_op1_d  = '0;
      iss_op2t_d = '0;
      iss_op2_d  = '0;
      iss_rd_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < ENTRIES; e++) ent_q[e] <= '0;
      iss_vld_q  <= '0;
      iss_cmd_q  <= '0;
      iss_op1_q  <= '0;
      iss_op2t_q <= '0;
      iss_op2_q  <= '0;
      iss_rd_q   <= '0;
    end else begin
      for (int e = 0; e < ENTRIES; e++) ent_q[e] <= ent_d[e];
      iss_vld_q  <= iss_vld_d;
      iss_cmd_q  <= iss_cmd_d;
      iss_op1_q  <= iss_op1_d;
      iss_op2t_q <= iss_op2t_d;
      iss_op2_q  <= iss_op2_d;
      iss_rd_q   <= iss_rd_d;
    end
  end

  assign issue_valid_o    = iss_vld_q;
  assign issue_alu_cmd_o  = iss_cmd_q;
  assign issue_op1_o      = iss_op1_q;
  assign issue_op2_type_o = iss_op2t_q;
  assign issue_op2_o      = iss_op2_q;
  assign issue_phys_rd_o  = iss_rd_q;

endmodule
